// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output serializer.
package fft_pkg;

  localparam int unsigned FftN = 8;
  localparam int unsigned FftW = 16;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } fft_state_e;

  // Reverse the low 'bits' bits of 'value'.
  function automatic int unsigned bitrev(input int unsigned value, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < bits) begin
        r[bits-1-i] = value[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pace_counter.sv
// Saturating beat-pacing counter: tick is high once CLK_DIV-1 cycles have elapsed since clear.
module fft_pace_counter #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic fastclk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/fft_output_serializer.sv
// Captures one N-point complex frame and streams it out one bin per paced beat.
// Define FFT_OUT_BITREV_EN when the incoming slots are in bit-reversed order.
module fft_output_serializer
  import fft_pkg::*;
#(
  parameter int unsigned N            = FftN,
  parameter int unsigned W            = FftW,
  parameter int unsigned CLK_DIV      = 50,
  parameter bit          ZERO_REAL_IM = 1'b1
) (
  input  logic                 fastclk,
  input  logic                 rst_n,
  input  logic [N*W-1:0]       in_re,
  input  logic [N*W-1:0]       in_im,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [W-1:0]         out_re,
  output logic [W-1:0]         out_im,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned IdxW = $clog2(N);

  fft_state_e state_q, state_d;

  logic [N*W-1:0]  buf_re_q, buf_im_q;
  // One extra bit so rd_idx_q == N marks "all bins issued".
  logic [IdxW:0]   rd_idx_q;
  logic [IdxW-1:0] rd_slot;
  logic [W-1:0]    sel_re, sel_im;
  logic            zero_im;

  logic capture, issue, accept, last_accept, slot_free, bins_left, tick;

  fft_pace_counter #(
    .CLK_DIV(CLK_DIV)
  ) u_pace (
    .fastclk(fastclk),
    .rst_n  (rst_n),
    .en     (state_q == StStream),
    .clr    (capture || issue),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (capture) state_d = StStream;
      StStream: if (last_accept) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Handshake and control outputs.
  always_comb begin
    in_ready    = (state_q == StIdle);
    busy        = (state_q != StIdle);
    capture     = in_valid && (state_q == StIdle);
    slot_free   = !out_valid || out_ready;
    bins_left   = (rd_idx_q < (IdxW+1)'(N));
    issue       = (state_q == StStream) && tick && slot_free && bins_left;
    accept      = out_valid && out_ready;
    last_accept = accept && out_last;
  end

`ifdef FFT_OUT_BITREV_EN
  assign rd_slot = IdxW'(bitrev(32'(rd_idx_q[IdxW-1:0]), IdxW));
`else
  assign rd_slot = rd_idx_q[IdxW-1:0];
`endif

  // Bins 0 and N/2 are purely real for a real-valued input sequence.
  assign zero_im = ZERO_REAL_IM &&
                   ((rd_idx_q[IdxW-1:0] == '0) || (rd_idx_q[IdxW-1:0] == IdxW'(N / 2)));
  assign sel_re  = buf_re_q[rd_slot*W +: W];
  assign sel_im  = zero_im ? '0 : buf_im_q[rd_slot*W +: W];

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      buf_re_q  <= '0;
      buf_im_q  <= '0;
      rd_idx_q  <= '0;
      out_re    <= '0;
      out_im    <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (capture) begin
        buf_re_q <= in_re;
        buf_im_q <= in_im;
        rd_idx_q <= '0;
      end
      if (issue) begin
        out_re    <= sel_re;
        out_im    <= sel_im;
        out_index <= rd_idx_q[IdxW-1:0];
        out_valid <= 1'b1;
        out_last  <= (rd_idx_q == (IdxW+1)'(N - 1));
        rd_idx_q  <= rd_idx_q + (IdxW+1)'(1);
      end else if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Directed bench: nominal frame, backpressure, ignored input, mid-frame reset, CLK_DIV=1 stream.
module tb_fft_output_serializer;

  localparam int unsigned N = 8;
  localparam int unsigned W = 16;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
  } vec_t;

  logic fastclk = 1'b0;
  logic rst_n   = 1'b0;

  logic [N*W-1:0] in_re, in_im;
  logic           in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [W-1:0]   out_re, out_im;
  logic [2:0]     out_index;

  logic [N*W-1:0] f_in_re, f_in_im;
  logic           f_in_valid, f_in_ready, f_out_valid, f_out_last, f_busy;
  logic [W-1:0]   f_out_re, f_out_im;
  logic [2:0]     f_out_index;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t nom[8];
  int   fexp[8];
  int   w;

  always #5 fastclk = ~fastclk;

  fft_output_serializer #(
    .N(N), .W(W), .CLK_DIV(4), .ZERO_REAL_IM(1'b1)
  ) u_dut (
    .fastclk(fastclk), .rst_n(rst_n), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
    .in_ready(in_ready), .out_re(out_re), .out_im(out_im), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  fft_output_serializer #(
    .N(N), .W(W), .CLK_DIV(1), .ZERO_REAL_IM(1'b1)
  ) u_dut_fast (
    .fastclk(fastclk), .rst_n(rst_n), .in_re(f_in_re), .in_im(f_in_im), .in_valid(f_in_valid),
    .in_ready(f_in_ready), .out_re(f_out_re), .out_im(f_out_im), .out_index(f_out_index),
    .out_valid(f_out_valid), .out_ready(1'b1), .out_last(f_out_last), .busy(f_busy)
  );

  task automatic tick_();
    @(posedge fastclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_beat(input vec_t v);
    string tag;
    tag = $sformatf("bin%0d", v.idx);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " index"}, 32'(out_index), 32'(v.idx));
    check({tag, " re"}, 32'(out_re), 32'(v.re));
    check({tag, " im"}, 32'(out_im), 32'(v.im));
    check({tag, " last"}, 32'(out_last), 32'(v.last));
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
  endtask

  // Advance until out_valid, bounded; returns cycles waited.
  task automatic wait_beat(output int waited);
    waited = 0;
    do begin
      tick_();
      waited++;
    end while (!out_valid && waited < 100);
  endtask

  task automatic load_nominal();
    for (int k = 0; k < 8; k++) begin
      in_re[k*16 +: 16] = 16'(16 * k + 1);
      in_im[k*16 +: 16] = 16'(-(k + 1));
    end
  endtask

  task automatic capture();
    check("capture in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    tick_();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nom[0] = '{3'd0, 16'd1,   16'h0000, 1'b0};
    nom[1] = '{3'd1, 16'd17,  16'hFFFE, 1'b0};
    nom[2] = '{3'd2, 16'd33,  16'hFFFD, 1'b0};
    nom[3] = '{3'd3, 16'd49,  16'hFFFC, 1'b0};
    nom[4] = '{3'd4, 16'd65,  16'h0000, 1'b0};
    nom[5] = '{3'd5, 16'd81,  16'hFFFA, 1'b0};
    nom[6] = '{3'd6, 16'd97,  16'hFFF9, 1'b0};
    nom[7] = '{3'd7, 16'd113, 16'hFFF8, 1'b1};
`ifdef FFT_OUT_BITREV_EN
    fexp = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    fexp = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    in_valid = 1'b0; out_ready = 1'b1; in_re = '0; in_im = '0;
    f_in_valid = 1'b0; f_in_re = '0; f_in_im = '0;

    // Reset state
    repeat (3) tick_();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_re", 32'(out_re), 32'd0);
    check("rst out_im", 32'(out_im), 32'd0);
    check("rst out_index", 32'(out_index), 32'd0);
    check("rst fast in_ready", 32'(f_in_ready), 32'd1);
    rst_n = 1'b1;
    tick_();

    // Nominal frame
    load_nominal();
    capture();
    for (int k = 0; k < 8; k++) begin
      wait_beat(w);
      check($sformatf("nominal spacing bin%0d", k), 32'(w), 32'd4);
      check_beat(nom[k]);
    end
    tick_();
    check("nominal end out_valid", 32'(out_valid), 32'd0);
    check("nominal end in_ready", 32'(in_ready), 32'd1);
    check("nominal end busy", 32'(busy), 32'd0);

    // Backpressure on bin 2 with junk frame offered during STREAM
    capture();
    in_valid = 1'b1;
    in_re = {N{16'h7FFF}};
    in_im = {N{16'h7FFF}};
    for (int k = 0; k < 3; k++) begin
      wait_beat(w);
      check($sformatf("bp spacing bin%0d", k), 32'(w), 32'd4);
      check_beat(nom[k]);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_();
      check_beat(nom[2]);
    end
    out_ready = 1'b1;
    tick_();
    check_beat(nom[3]);
    for (int k = 4; k < 8; k++) begin
      if (k == 7) in_valid = 1'b0;
      wait_beat(w);
      check($sformatf("bp spacing bin%0d", k), 32'(w), 32'd4);
      check_beat(nom[k]);
    end
    tick_();
    check("bp end out_valid", 32'(out_valid), 32'd0);
    check("bp end in_ready", 32'(in_ready), 32'd1);

    // Reset mid-frame after bin 5 is accepted
    load_nominal();
    capture();
    for (int k = 0; k < 6; k++) begin
      wait_beat(w);
      check_beat(nom[k]);
    end
    tick_();
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_index", 32'(out_index), 32'd0);
    check("midrst out_re", 32'(out_re), 32'd0);
    check("midrst out_im", 32'(out_im), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    tick_();
    rst_n = 1'b1;
    tick_();
    capture();
    for (int k = 0; k < 8; k++) begin
      wait_beat(w);
      check($sformatf("restart spacing bin%0d", k), 32'(w), 32'd4);
      check_beat(nom[k]);
    end
    tick_();
    check("restart end in_ready", 32'(in_ready), 32'd1);

    // CLK_DIV=1: back-to-back beats
    for (int j = 0; j < 8; j++) f_in_re[j*16 +: 16] = 16'(j);
    f_in_valid = 1'b1;
    tick_();
    f_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick_();
      check($sformatf("fast valid bin%0d", k), 32'(f_out_valid), 32'd1);
      check($sformatf("fast index bin%0d", k), 32'(f_out_index), 32'(k));
      check($sformatf("fast re bin%0d", k), 32'(f_out_re), 32'(fexp[k]));
      check($sformatf("fast last bin%0d", k), 32'(f_out_last), 32'(k == 7));
    end
    tick_();
    check("fast end out_valid", 32'(f_out_valid), 32'd0);
    check("fast end in_ready", 32'(f_in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
